sim_ctrl_monitor: RTL and testbench

Synthesizable, parametrised simulation-control monitor that snoops the SoC data-memory request port and turns writes to magic addresses into stop, trap, and register-dump events. It generalises the bench-side stop/trap/dump logic into RTL so the same termination rules hold in simulation, emulation and FPGA runs. It sits beside the core inside the tiny SoC wrapper, next to the data-memory port, and exports a registered termination status plus a buffered dump stream.

---
 rtl/sim_ctrl_monitor.sv | 239 +++++++++++++++++++++++
 tb/tb_sim_ctrl_monitor.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl_monitor.sv
// sim_ctrl_monitor: watches the data-memory request port and reacts to writes
// at magic addresses. It produces stop, trap and register-dump events, a
// registered run status (done/cause/cycle/trap count) and a small dump FIFO.
module sim_ctrl_monitor #(
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       DATA_W          = 64,
    parameter logic [ADDR_W-1:0] ADDR_STOP       = 'h0,
    parameter logic [ADDR_W-1:0] ADDR_TRAP       = 'h8,
    parameter logic [ADDR_W-1:0] ADDR_IDUMP      = 'h10,
    parameter logic [ADDR_W-1:0] ADDR_FDUMP      = 'h18,
    parameter int unsigned       DRAIN_CYCLES    = 50,
    parameter int unsigned       PC_GUARD_CYCLES = 10,
    parameter int unsigned       FIFO_DEPTH      = 4,
    parameter int unsigned       CNT_W           = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_i,
    input  logic              mem_gnt_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              pc_unknown_i,
    input  logic              stop_on_trap_i,
    input  logic [CNT_W-1:0]  simlen_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic              dump_is_float_o,
    output logic [4:0]        dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_overflow_o,
    output logic              done_o,
    output logic [2:0]        cause_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [CNT_W-1:0]  trap_count_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_STOP   = 3'd1;
    localparam logic [2:0] CAUSE_TRAP   = 3'd2;
    localparam logic [2:0] CAUSE_PCX    = 3'd3;
    localparam logic [2:0] CAUSE_SIMLEN = 3'd4;

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = PTR_W + 1;
    localparam int unsigned DRN_W      = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [DRN_W-1:0]      DRAIN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]      PC_GUARD   = CNT_W'(PC_GUARD_CYCLES);
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL  = FIFO_CNT_W'(FIFO_DEPTH);

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Integer register x0 is never dumped, so the index cycles 1..31.
    function automatic logic [4:0] next_int_idx(input logic [4:0] idx);
        return (idx == 5'd31) ? 5'd1 : idx + 5'd1;
    endfunction

    logic [1:0]            state;
    logic [DRN_W-1:0]      drain_cnt;
    logic [4:0]            int_idx;
    logic [4:0]            fp_idx;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FIFO_CNT_W-1:0] fifo_cnt;

    logic                  fifo_flt [FIFO_DEPTH];
    logic [4:0]            fifo_idx [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_dat [FIFO_DEPTH];

    logic                  wr_acc;
    logic                  in_run;
    logic                  hit_stop;
    logic                  hit_trap;
    logic                  hit_idump;
    logic                  hit_fdump;
    logic                  trig_drain;
    logic [2:0]            trig_cause;
    logic                  trig_simlen;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  fifo_full;
    logic                  push_flt;
    logic [4:0]            push_idx;
    logic [DATA_W-1:0]     push_dat;

    // Magic-address hits only count while the run is still live.
    assign wr_acc    = mem_req_i & mem_gnt_i & mem_we_i;
    assign in_run    = (state == ST_RUN);
    assign hit_stop  = in_run && wr_acc && (mem_addr_i == ADDR_STOP);
    assign hit_trap  = in_run && wr_acc && (mem_addr_i == ADDR_TRAP);
    assign hit_idump = in_run && wr_acc && (mem_addr_i == ADDR_IDUMP);
    assign hit_fdump = in_run && wr_acc && (mem_addr_i == ADDR_FDUMP);

    // Prioritised selection of the causes that enter the drain phase.
    always_comb begin
        trig_drain = 1'b0;
        trig_cause = CAUSE_NONE;
        if (hit_stop) begin
            trig_drain = 1'b1;
            trig_cause = CAUSE_STOP;
        end else if (hit_trap && stop_on_trap_i) begin
            trig_drain = 1'b1;
            trig_cause = CAUSE_TRAP;
        end else if (in_run && pc_unknown_i && (cycle_o >= PC_GUARD)) begin
            trig_drain = 1'b1;
            trig_cause = CAUSE_PCX;
        end
    end

    // Equality only: lowering simlen_i below the current cycle never fires.
    assign trig_simlen = in_run && !trig_drain && (simlen_i != '0) &&
                         (cycle_o == simlen_i - CNT_W'(1));

    // Run/drain/done sequencing with latched cause and sticky done.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            cause_o   <= CAUSE_NONE;
            done_o    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (trig_drain) begin
                        cause_o   <= trig_cause;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= ST_DRAIN;
                    end else if (trig_simlen) begin
                        cause_o <= CAUSE_SIMLEN;
                        done_o  <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Cycle counter runs until DONE; trap counter counts live trap writes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycle_o      <= '0;
            trap_count_o <= '0;
        end else begin
            if (state != ST_DONE) begin
                cycle_o <= sat_inc(cycle_o);
            end
            if (hit_trap) begin
                trap_count_o <= sat_inc(trap_count_o);
            end
        end
    end

    // Register indices advance on every accepted dump, dropped or not.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            int_idx <= 5'd1;
            fp_idx  <= 5'd0;
        end else begin
            if (hit_idump) begin
                int_idx <= next_int_idx(int_idx);
            end
            if (hit_fdump) begin
                fp_idx <= fp_idx + 5'd1;
            end
        end
    end

    assign push_req  = hit_idump || hit_fdump;
    assign pop       = dump_valid_o && dump_ready_i;
    assign fifo_full = (fifo_cnt == FIFO_FULL);
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_flt  = hit_fdump;
    assign push_idx  = hit_fdump ? fp_idx : int_idx;
    assign push_dat  = hit_fdump ? mem_wdata_i : DATA_W'(mem_wdata_i[31:0]);

    // FIFO control: pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            dump_overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FIFO_CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FIFO_CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_req && fifo_full && !pop) begin
                dump_overflow_o <= 1'b1;
            end
        end
    end

    // FIFO storage is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_flt[wr_ptr] <= push_flt;
            fifo_idx[wr_ptr] <= push_idx;
            fifo_dat[wr_ptr] <= push_dat;
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    assign dump_valid_o    = (fifo_cnt != '0);
    assign dump_is_float_o = dump_valid_o & fifo_flt[rd_ptr];
    assign dump_idx_o      = dump_valid_o ? fifo_idx[rd_ptr] : 5'd0;
    assign dump_data_o     = dump_valid_o ? fifo_dat[rd_ptr] : '0;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Bench for sim_ctrl_monitor: randomized traffic against an event-time
// reference model (cause cycle + drain length) and a queue model of the FIFO.
module tb_sim_ctrl_monitor;

    localparam int DRAIN = 50;
    localparam int GUARD = 10;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_STOP  = 32'h0;
    localparam logic [31:0] A_TRAP  = 32'h8;
    localparam logic [31:0] A_IDUMP = 32'h10;
    localparam logic [31:0] A_FDUMP = 32'h18;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        mem_req_i, mem_gnt_i, mem_we_i;
    logic [31:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic        pc_unknown_i, stop_on_trap_i;
    logic [31:0] simlen_i;
    logic        dump_valid_o, dump_ready_i, dump_is_float_o;
    logic [4:0]  dump_idx_o;
    logic [63:0] dump_data_o;
    logic        dump_overflow_o, done_o;
    logic [2:0]  cause_o;
    logic [31:0] cycle_o, trap_count_o;

    always #5 clk = ~clk;

    sim_ctrl_monitor #(
        .ADDR_W(32), .DATA_W(64), .ADDR_STOP(A_STOP), .ADDR_TRAP(A_TRAP),
        .ADDR_IDUMP(A_IDUMP), .ADDR_FDUMP(A_FDUMP), .DRAIN_CYCLES(DRAIN),
        .PC_GUARD_CYCLES(GUARD), .FIFO_DEPTH(DEPTH), .CNT_W(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(mem_req_i), .mem_gnt_i(mem_gnt_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .pc_unknown_i(pc_unknown_i), .stop_on_trap_i(stop_on_trap_i), .simlen_i(simlen_i),
        .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
        .dump_is_float_o(dump_is_float_o), .dump_idx_o(dump_idx_o),
        .dump_data_o(dump_data_o), .dump_overflow_o(dump_overflow_o),
        .done_o(done_o), .cause_o(cause_o), .cycle_o(cycle_o), .trap_count_o(trap_count_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        flt;
        logic [4:0]  idx;
        logic [63:0] dat;
    } ent_t;

    // Reference model state: cycles since reset, first cause and its cycle.
    int   m_t, m_cause, m_ev, m_traps, m_int_n, m_fp_n;
    bit   m_ovf;
    ent_t m_q[$];

    function automatic int done_at();
        return (m_cause == 4) ? m_ev + 1 : m_ev + DRAIN + 2;
    endfunction

    function automatic bit exp_done();
        return (m_cause != 0) && (m_t >= done_at());
    endfunction

    function automatic int exp_cycle();
        return exp_done() ? done_at() : m_t;
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0; mem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; pc_unknown_i = 1'b0;
        stop_on_trap_i = 1'b0; simlen_i = '0; dump_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        m_t = 0; m_cause = 0; m_ev = 0; m_traps = 0; m_int_n = 0; m_fp_n = 0;
        m_ovf = 1'b0; m_q.delete();
    endtask

    // Drives one cycle of traffic and advances the model across the edge.
    task automatic step(input logic req, input logic gnt, input logic we,
                        input logic [31:0] addr, input logic [63:0] wdata);
        logic acc, pop, dump, push_ok;
        ent_t e;
        acc = req & gnt & we;
        pop = (m_q.size() != 0) && dump_ready_i;
        dump = 1'b0; push_ok = 1'b0; e = '0;
        mem_req_i = req; mem_gnt_i = gnt; mem_we_i = we;
        mem_addr_i = addr; mem_wdata_i = wdata;
        if (m_cause == 0) begin
            dump = acc && (addr == A_IDUMP || addr == A_FDUMP);
            if (acc && addr == A_TRAP) m_traps++;
            if (dump && addr == A_FDUMP) begin
                e.flt = 1'b1; e.idx = 5'(m_fp_n % 32); e.dat = wdata; m_fp_n++;
            end else if (dump) begin
                e.flt = 1'b0; e.idx = 5'(1 + m_int_n % 31); e.dat = {32'h0, wdata[31:0]}; m_int_n++;
            end
            if (acc && addr == A_STOP) begin m_cause = 1; m_ev = m_t; end
            else if (acc && addr == A_TRAP && stop_on_trap_i) begin m_cause = 2; m_ev = m_t; end
            else if (pc_unknown_i && m_t >= GUARD) begin m_cause = 3; m_ev = m_t; end
            else if (simlen_i != 0 && m_t == int'(simlen_i) - 1) begin m_cause = 4; m_ev = m_t; end
        end
        if (dump) begin
            if (m_q.size() < DEPTH || pop) push_ok = 1'b1;
            else m_ovf = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(e);
        m_t++;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    // Bus activity that must never be taken as a magic write.
    task automatic idle_noise();
        int unsigned r;
        r = $urandom_range(0, 3);
        case (r)
            0: idle();
            1: step(1'b1, 1'b0, 1'b1, A_STOP, {$urandom, $urandom});
            2: step(1'b1, 1'b1, 1'b0, A_STOP, {$urandom, $urandom});
            default: step(1'b1, 1'b1, 1'b1, 32'h100 + 32'($urandom_range(0, 255) * 4), {$urandom, $urandom});
        endcase
    endtask

    task automatic test_reset();
        int n;
        rst_ni = 1'b0; mem_req_i = 1'b1; mem_gnt_i = 1'b1; mem_we_i = 1'b1;
        mem_addr_i = A_IDUMP; mem_wdata_i = {$urandom, $urandom}; pc_unknown_i = 1'b1;
        stop_on_trap_i = 1'b1; simlen_i = 32'd1; dump_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_o); end
        checks++; if (cause_o !== 3'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", cause_o); end
        checks++; if (cycle_o !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d want 0", cycle_o); end
        checks++; if (trap_count_o !== 32'd0) begin errors++; $display("FAIL reset_traps: got %0d want 0", trap_count_o); end
        checks++; if (dump_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", dump_valid_o); end
        checks++; if (dump_overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", dump_overflow_o); end
        checks++; if ({dump_is_float_o, dump_idx_o, dump_data_o} !== 70'd0) begin
            errors++; $display("FAIL reset_head: got %0b/%0d/%h want all zero", dump_is_float_o, dump_idx_o, dump_data_o); end
        do_reset();
        n = $urandom_range(3, 12);
        repeat (n) idle_noise();
        checks++; if (cycle_o !== 32'(exp_cycle())) begin errors++; $display("FAIL count_cycle: got %0d want %0d", cycle_o, exp_cycle()); end
        checks++; if (cause_o !== 3'd0) begin errors++; $display("FAIL count_cause: got %0d want 0", cause_o); end
    endtask

    task automatic test_stop();
        int s;
        do_reset();
        s = $urandom_range(20, 120);
        while (m_t < s) idle_noise();
        step(1'b1, 1'b1, 1'b1, A_STOP, {$urandom, $urandom});
        checks++; if (cause_o !== 3'(m_cause) || m_cause != 1) begin errors++; $display("FAIL stop_cause: got %0d want 1", cause_o); end
        checks++; if (cycle_o !== 32'(s + 1)) begin errors++; $display("FAIL stop_cycle: got %0d want %0d", cycle_o, s + 1); end
        for (int k = 0; k < DRAIN + 1; k++) begin
            checks++; if (done_o !== exp_done()) begin errors++; $display("FAIL drain_done_t%0d: got %0b want %0b", m_t, done_o, exp_done()); end
            if (k == 3) step(1'b1, 1'b1, 1'b1, A_TRAP, {$urandom, $urandom});
            else if (k == 7) step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
            else idle();
        end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL stop_done: got %0b want 1", done_o); end
        checks++; if (cycle_o !== 32'(s + DRAIN + 2)) begin errors++; $display("FAIL stop_frozen: got %0d want %0d", cycle_o, s + DRAIN + 2); end
        checks++; if (trap_count_o !== 32'(m_traps)) begin errors++; $display("FAIL drain_trap_ignored: got %0d want %0d", trap_count_o, m_traps); end
        checks++; if (dump_valid_o !== 1'b0) begin errors++; $display("FAIL drain_dump_ignored: got %0b want 0", dump_valid_o); end
        repeat (5) idle_noise();
        checks++; if (cycle_o !== 32'(exp_cycle()) || cause_o !== 3'd1) begin
            errors++; $display("FAIL done_hold: got cycle %0d cause %0d want %0d 1", cycle_o, cause_o, exp_cycle()); end
    endtask

    task automatic test_trap();
        int n, k;
        do_reset();
        stop_on_trap_i = 1'b0;
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) idle_noise();
            step(1'b1, 1'b1, 1'b1, A_TRAP, {$urandom, $urandom});
        end
        checks++; if (trap_count_o !== 32'(n)) begin errors++; $display("FAIL trap_count: got %0d want %0d", trap_count_o, n); end
        checks++; if (cause_o !== 3'd0 || done_o !== 1'b0) begin errors++; $display("FAIL trap_nostop: got cause %0d done %0b want 0 0", cause_o, done_o); end
        stop_on_trap_i = 1'b1;
        step(1'b1, 1'b1, 1'b1, A_TRAP, {$urandom, $urandom});
        checks++; if (cause_o !== 3'(m_cause) || m_cause != 2) begin errors++; $display("FAIL trap_cause: got %0d want 2", cause_o); end
        checks++; if (trap_count_o !== 32'(n + 1)) begin errors++; $display("FAIL trap_count_stop: got %0d want %0d", trap_count_o, n + 1); end
        k = 0;
        while (!exp_done() && k < 200) begin idle(); k++; end
        checks++; if (done_o !== 1'b1 || cycle_o !== 32'(exp_cycle())) begin
            errors++; $display("FAIL trap_done: got done %0b cycle %0d want 1 %0d", done_o, cycle_o, exp_cycle()); end
    endtask

    task automatic test_dumps();
        int unsigned op;
        do_reset();
        dump_ready_i = 1'b1;
        for (int i = 0; i < 34 + 3; i++) begin
            checks++; if (dump_valid_o !== (m_q.size() != 0)) begin errors++; $display("FAIL dump_valid_%0d: got %0b want %0b", i, dump_valid_o, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if ({dump_is_float_o, dump_idx_o, dump_data_o} !== m_q[0]) begin
                    errors++; $display("FAIL dump_head_%0d: got %0b/%0d/%h want %0b/%0d/%h", i, dump_is_float_o, dump_idx_o, dump_data_o, m_q[0].flt, m_q[0].idx, m_q[0].dat); end
            end
            if (i < 32) step(1'b1, 1'b1, 1'b1, A_IDUMP, 64'hDEADBEEF_CAFEF00D);
            else if (i < 34) step(1'b1, 1'b1, 1'b1, A_FDUMP, 64'hDEADBEEF_CAFEF00D);
            else idle();
        end
        for (int i = 0; i < 80; i++) begin
            checks++; if (dump_valid_o !== (m_q.size() != 0) || dump_overflow_o !== m_ovf) begin
                errors++; $display("FAIL rnd_flags_%0d: got v%0b o%0b want v%0b o%0b", i, dump_valid_o, dump_overflow_o, m_q.size() != 0, m_ovf); end
            if (m_q.size() != 0) begin
                checks++; if ({dump_is_float_o, dump_idx_o, dump_data_o} !== m_q[0]) begin
                    errors++; $display("FAIL rnd_head_%0d: got %0b/%0d/%h want %0b/%0d/%h", i, dump_is_float_o, dump_idx_o, dump_data_o, m_q[0].flt, m_q[0].idx, m_q[0].dat); end
            end
            dump_ready_i = (i < 70) ? 1'($urandom_range(0, 1)) : 1'b1;
            op = (i < 70) ? $urandom_range(0, 3) : 0;
            case (op)
                1: step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
                2: step(1'b1, 1'b1, 1'b1, A_FDUMP, {$urandom, $urandom});
                3: idle_noise();
                default: idle();
            endcase
        end
        checks++; if (dump_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_empty: got %0b want 0", dump_valid_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        dump_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
        checks++; if (dump_overflow_o !== 1'b1 || m_ovf != 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", dump_overflow_o); end
        dump_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dump_valid_o !== 1'b1 || dump_idx_o !== 5'(i + 1) || dump_data_o !== m_q[0].dat) begin
                errors++; $display("FAIL ovf_pop_%0d: got v%0b idx %0d want v1 idx %0d", i, dump_valid_o, dump_idx_o, i + 1); end
            idle();
        end
        checks++; if (dump_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b want 0", dump_valid_o); end
    endtask

    task automatic test_back_to_back();
        int pops;
        do_reset();
        dump_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
        dump_ready_i = 1'b1;
        step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
        dump_ready_i = 1'b0;
        idle();
        checks++; if (dump_overflow_o !== 1'b0 || m_ovf) begin errors++; $display("FAIL b2b_ovf: got %0b want 0", dump_overflow_o); end
        dump_ready_i = 1'b1;
        pops = 0;
        while (dump_valid_o === 1'b1 && pops < 10) begin
            checks++; if (m_q.size() == 0 || {dump_is_float_o, dump_idx_o, dump_data_o} !== m_q[0]) begin
                errors++; $display("FAIL b2b_head_%0d: got idx %0d want %0d", pops, dump_idx_o, pops + 2); end
            idle();
            pops++;
        end
        checks++; if (pops != 4) begin errors++; $display("FAIL b2b_occupancy: got %0d entries want 4", pops); end
    endtask

    task automatic test_pc_unknown();
        int k;
        do_reset();
        while (m_t < 5) idle();
        pc_unknown_i = 1'b1;
        while (m_t < GUARD) begin
            idle();
            checks++; if (cause_o !== 3'd0) begin errors++; $display("FAIL pc_guard_t%0d: got %0d want 0", m_t, cause_o); end
        end
        step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
        checks++; if (cause_o !== 3'(m_cause) || m_cause != 3) begin errors++; $display("FAIL pc_cause: got %0d want 3", cause_o); end
        checks++; if (dump_valid_o !== 1'b1 || dump_idx_o !== 5'd1) begin errors++; $display("FAIL pc_same_cycle_dump: got v%0b idx %0d want v1 idx 1", dump_valid_o, dump_idx_o); end
        pc_unknown_i = 1'b0;
        step(1'b1, 1'b1, 1'b1, A_STOP, {$urandom, $urandom});
        checks++; if (cause_o !== 3'd3) begin errors++; $display("FAIL pc_stop_ignored: got %0d want 3", cause_o); end
        k = 0;
        while (!exp_done() && k < 200) begin idle(); k++; end
        checks++; if (done_o !== 1'b1 || cycle_o !== 32'(GUARD + DRAIN + 2)) begin
            errors++; $display("FAIL pc_done: got done %0b cycle %0d want 1 %0d", done_o, cycle_o, GUARD + DRAIN + 2); end
    endtask

    task automatic test_simlen();
        int k;
        do_reset();
        simlen_i = 32'd200;
        while (m_t < 199) idle_noise();
        checks++; if (done_o !== 1'b0 || cause_o !== 3'd0) begin errors++; $display("FAIL simlen_early: got done %0b cause %0d want 0 0", done_o, cause_o); end
        step(1'b1, 1'b1, 1'b1, A_FDUMP, {$urandom, $urandom});
        checks++; if (done_o !== 1'b1 || cause_o !== 3'd4) begin errors++; $display("FAIL simlen_done: got done %0b cause %0d want 1 4", done_o, cause_o); end
        checks++; if (dump_valid_o !== 1'b1 || {dump_is_float_o, dump_idx_o, dump_data_o} !== m_q[0]) begin
            errors++; $display("FAIL simlen_dump: got v%0b idx %0d want v1 idx 0", dump_valid_o, dump_idx_o); end
        repeat (3) idle();
        checks++; if (cycle_o !== 32'd200) begin errors++; $display("FAIL simlen_cycle: got %0d want 200", cycle_o); end
        do_reset();
        while (m_t < 30) idle();
        simlen_i = 32'd10;
        repeat (20) idle();
        checks++; if (done_o !== 1'b0 || cause_o !== 3'd0) begin errors++; $display("FAIL simlen_lowered: got done %0b cause %0d want 0 0", done_o, cause_o); end
        simlen_i = 32'(m_t + 5);
        k = 0;
        while (!exp_done() && k < 20) begin idle(); k++; end
        checks++; if (done_o !== 1'b1 || cause_o !== 3'd4 || cycle_o !== 32'(exp_cycle())) begin
            errors++; $display("FAIL simlen_raised: got done %0b cause %0d cycle %0d want 1 4 %0d", done_o, cause_o, cycle_o, exp_cycle()); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
        repeat (2) step(1'b1, 1'b1, 1'b1, A_TRAP, {$urandom, $urandom});
        step(1'b1, 1'b1, 1'b1, A_STOP, {$urandom, $urandom});
        repeat (10) idle();
        checks++; if (cause_o !== 3'd1 || done_o !== 1'b0 || dump_overflow_o !== 1'b1) begin
            errors++; $display("FAIL middrain_pre: got cause %0d done %0b ovf %0b want 1 0 1", cause_o, done_o, dump_overflow_o); end
        rst_ni = 1'b0;
        @(posedge clk); #1;
        checks++; if ({done_o, cause_o, dump_valid_o, dump_overflow_o} !== 6'd0 || cycle_o !== 32'd0 || trap_count_o !== 32'd0) begin
            errors++; $display("FAIL middrain_reset: got done %0b cause %0d v %0b ovf %0b cyc %0d traps %0d want all 0",
                               done_o, cause_o, dump_valid_o, dump_overflow_o, cycle_o, trap_count_o); end
        do_reset();
        step(1'b1, 1'b1, 1'b1, A_IDUMP, {$urandom, $urandom});
        checks++; if (dump_valid_o !== 1'b1 || dump_idx_o !== 5'd1 || cycle_o !== 32'd1) begin
            errors++; $display("FAIL middrain_restart: got v%0b idx %0d cyc %0d want v1 idx 1 cyc 1", dump_valid_o, dump_idx_o, cycle_o); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; mem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; pc_unknown_i = 1'b0; stop_on_trap_i = 1'b0;
        simlen_i = '0; dump_ready_i = 1'b0;
        #1;
        test_reset();
        test_stop();
        test_trap();
        test_dumps();
        test_overflow();
        test_back_to_back();
        test_pc_unknown();
        test_simlen();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
